// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture block: FSM encoding, default
// resolution and the counter saturation value.
package pwm_pkg;

    localparam int DEF_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } cap_state_t;

    // All-ones value of a width-bit counter; doubles as the timeout value.
    function automatic int unsigned sat_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Input conditioning for capture blocks: 2-flop synchronizer, optional
// debounce (enabled by PWM_CAP_GLITCH_EN) and rise/fall detection.
// A valid chain follows the data through the pipeline so that the
// zeroed flops left by reset are never mistaken for a real edge.
module pwm_edge_sync
`ifdef PWM_CAP_GLITCH_EN
#(
    parameter int GLITCH = 3
)
`endif
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pin,
    output logic o_lvl,
    output logic o_rise,
    output logic o_fall
);

    logic r_s1, r_s2, r_v1, r_v2;
    logic r_sd, r_vd;
    logic w_lvl, w_lvl_vld;

    // Synchronize the pin and track when the synchronized sample becomes real.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            r_s1 <= i_pin;
            r_s2 <= r_s1;
            r_v1 <= 1'b1;
            r_v2 <= r_v1;
        end
    end

`ifdef PWM_CAP_GLITCH_EN
    localparam int GW = $clog2(GLITCH + 1);

    logic [GW-1:0] r_gcnt;
    logic          r_filt;
    logic          r_vf;

    // Follow the synchronized level only after it has disagreed for GLITCH cycles;
    // the first valid sample is loaded directly so reset does not create an edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_gcnt <= '0;
            r_filt <= 1'b0;
            r_vf   <= 1'b0;
        end else begin
            r_vf <= r_v2;
            if (!r_vf) begin
                r_filt <= r_s2;
                r_gcnt <= '0;
            end else if (r_s2 != r_filt) begin
                if (r_gcnt == GW'(GLITCH - 1)) begin
                    r_filt <= r_s2;
                    r_gcnt <= '0;
                end else begin
                    r_gcnt <= r_gcnt + 1'b1;
                end
            end else begin
                r_gcnt <= '0;
            end
        end
    end

    assign w_lvl     = r_filt;
    assign w_lvl_vld = r_vf;
`else
    assign w_lvl     = r_s2;
    assign w_lvl_vld = r_v2;
`endif

    // Delayed copy of the conditioned level for edge detection.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sd <= 1'b0;
            r_vd <= 1'b0;
        end else begin
            r_sd <= w_lvl;
            r_vd <= w_lvl_vld;
        end
    end

    assign o_lvl  = w_lvl;
    assign o_rise = r_vd &  w_lvl & ~r_sd;
    assign o_fall = r_vd & ~w_lvl &  r_sd;

endmodule

// File: rtl/pwm_capture.sv
// PWM decoder: measures high time and period (rising edge to rising edge)
// in clk cycles and flags edge-less inputs. Define PWM_CAP_GLITCH_EN to
// insert a GLITCH-cycle debounce ahead of the edge detector.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no period in progress; idle counter watches for a flat input
// HIGH    | inside the high phase; high and period counters running
// LOW     | inside the low phase; period counter running until next rise
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int BITS = DEF_BITS,
    parameter int CW   = BITS + 2
`ifdef PWM_CAP_GLITCH_EN
    , parameter int GLITCH = 3
`endif
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          pwm_in,
    output logic [CW-1:0] hi,
    output logic [CW-1:0] per,
    output logic          vld,
    output logic          stuck,
    output logic          lvl
);

    localparam logic [CW-1:0] MAX = CW'(sat_max(CW));

    cap_state_t    r_state, w_state_nx;
    logic [CW-1:0] r_hcnt, r_pcnt, r_icnt;
    logic [CW-1:0] w_hcnt_nx, w_pcnt_nx, w_icnt_nx;
    logic [CW-1:0] r_hi, r_per;
    logic          r_vld, r_stuck, r_lvl;
    logic          w_report, w_timeout;
    logic          w_lvl, w_rise, w_fall;

    pwm_edge_sync
`ifdef PWM_CAP_GLITCH_EN
    #(.GLITCH(GLITCH))
`endif
    u_sync (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_pin   (pwm_in),
        .o_lvl   (w_lvl),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    // Next state and counters; the fall cycle already belongs to the low phase,
    // so it advances only the period counter. A rise beats a coincident timeout.
    always_comb begin
        w_state_nx = r_state;
        w_hcnt_nx  = r_hcnt;
        w_pcnt_nx  = r_pcnt;
        w_icnt_nx  = r_icnt;
        w_report   = 1'b0;
        w_timeout  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nx = ST_HIGH;
                    w_hcnt_nx  = CW'(1);
                    w_pcnt_nx  = CW'(1);
                    w_icnt_nx  = '0;
                end else if (r_icnt == MAX - CW'(1)) begin
                    w_timeout = 1'b1;
                    w_icnt_nx = '0;
                end else begin
                    w_icnt_nx = r_icnt + CW'(1);
                end
            end
            ST_HIGH: begin
                if (r_pcnt == MAX) begin
                    w_timeout  = 1'b1;
                    w_state_nx = ST_IDLE;
                    w_icnt_nx  = '0;
                end else if (w_fall) begin
                    w_pcnt_nx  = r_pcnt + CW'(1);
                    w_state_nx = ST_LOW;
                end else begin
                    w_hcnt_nx = (r_hcnt == MAX) ? MAX : r_hcnt + CW'(1);
                    w_pcnt_nx = r_pcnt + CW'(1);
                end
            end
            ST_LOW: begin
                if (w_rise) begin
                    w_report   = 1'b1;
                    w_state_nx = ST_HIGH;
                    w_hcnt_nx  = CW'(1);
                    w_pcnt_nx  = CW'(1);
                end else if (r_pcnt == MAX) begin
                    w_timeout  = 1'b1;
                    w_state_nx = ST_IDLE;
                    w_icnt_nx  = '0;
                end else begin
                    w_pcnt_nx = r_pcnt + CW'(1);
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_icnt_nx  = '0;
            end
        endcase
    end

    // State, counters and registered result/strobe outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_hcnt  <= '0;
            r_pcnt  <= '0;
            r_icnt  <= '0;
            r_hi    <= '0;
            r_per   <= '0;
            r_vld   <= 1'b0;
            r_stuck <= 1'b0;
            r_lvl   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_hcnt  <= w_hcnt_nx;
            r_pcnt  <= w_pcnt_nx;
            r_icnt  <= w_icnt_nx;
            r_vld   <= w_report;
            r_stuck <= w_timeout;
            if (w_report) begin
                r_hi  <= r_hcnt;
                r_per <= r_pcnt;
            end
            if (w_timeout) begin
                r_lvl <= w_lvl;
            end
        end
    end

    assign hi    = r_hi;
    assign per   = r_per;
    assign vld   = r_vld;
    assign stuck = r_stuck;
    assign lvl   = r_lvl;

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- PWM decoder: samples an asynchronous PWM input and measures high time and period in clock cycles.
- Receive-side counterpart of the team's PWM generator. It recovers the generator's duty value from its output waveform, e.g. for loopback self-test or for reading external PWM sensors.
- Reports one measurement per input period, plus a stuck-level indication for 0%/100% (edge-less) inputs.

Parameters:
- BITS, 8: nominal duty resolution of the measured source. Informational; sets the CW default.
- CW, BITS+2: width of the high-time and period counters and outputs. All-ones is the timeout value.
- GLITCH, 3: stability window in cycles. Used only when PWM_CAP_GLITCH_EN is defined.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-low; clears all state on the clk edge where it is sampled low.
- pwm_in  in  1  asynchronous PWM input.
- hi  out  CW  last measured high time, in cycles.
- per  out  CW  last measured period (rising edge to rising edge), in cycles.
- vld  out  1  one-cycle strobe: hi/per updated this cycle.
- stuck  out  1  one-cycle strobe: no rising edge within the timeout.
- lvl  out  1  synchronized input level captured at the stuck event.

Behaviour:
- Reset (rst==0 at clk edge): hi=0, per=0, vld=0, stuck=0, lvl=0. Sync flops, counters and FSM are cleared; FSM goes to IDLE. Reset mid-measurement discards the partial count, and no vld is issued for it.
- Input path: 2-flop synchronizer, then a registered previous value. rise = s & ~s_d; fall = ~s & s_d.
- Fixed latency from pin to edge detection: 3 cycles. Latency is identical for both edges, so measured widths are exact.
- FSM states:
  - IDLE: wait for rise. On rise: hcnt=1, pcnt=1, go HIGH. The first partial period is never reported.
  - HIGH: hcnt++, pcnt++ each cycle. On fall: go LOW.
  - LOW: pcnt++ each cycle. On rise: hi<=hcnt, per<=pcnt, vld=1 on the next cycle, reload hcnt=1 and pcnt=1, go HIGH.
- Counters saturate at all-ones and never wrap.
- Timeout: when pcnt reaches 2^CW-1 in HIGH or LOW, assert stuck for one cycle, set lvl<=s, and go IDLE. hi/per hold their previous values.
- Timeout in IDLE: a separate idle counter triggers the same stuck/lvl behaviour, then restarts. stuck repeats every 2^CW-1 cycles while the input stays flat.
- Simultaneous rise and timeout on the same cycle: rise wins, and the measurement is reported with per = 2^CW-1.
- vld and stuck are never asserted in the same cycle.
- hi < per always holds for a reported measurement; hi >= 1 and per >= 2.

Optional Feature:
- Macro: PWM_CAP_GLITCH_EN.
- Defined: a debounce stage sits between the synchronizer and the edge detector. The filtered level changes only after the synchronized input differs from it for GLITCH consecutive cycles.
  - Pulses or gaps shorter than GLITCH cycles are ignored.
  - Latency grows by GLITCH cycles on both edges, so clean-input measurements are unchanged.
- Undefined: filter absent; the synchronizer output feeds the edge detector directly.

Decomposition:
- Shared package pwm_pkg:
  - FSM state encoding (IDLE, HIGH, LOW).
  - Default BITS.
  - Function for the counter saturation value.
- One sub-module: pwm_edge_sync. It contains the synchronizer, the optional glitch filter and the rise/fall detector. It outputs the level plus rise/fall strobes and is reusable by other input-capture blocks.

Test Plan:
- Loopback from the PWM generator (BITS=8) with dty=64 -> after the first full period, vld every 256 cycles with hi=64, per=256.
- Loopback with dty=255 -> hi=255, per=256. With dty=1 -> hi=1, per=256.
- Loopback with dty=0 (input constant 0) -> no vld; stuck pulses with lvl=0 first 1023 cycles after reset release, then every 1023 cycles. Constant-1 input -> lvl=1.
- Assert rst for 1 cycle mid-HIGH during a dty=128 stream -> all outputs 0 the next cycle. First vld only after two further rising edges, with hi=128, per=256.
- Duty step from 64 to 192 -> every vld reports either (64,256) or (192,256), except at most one transitional measurement. No vld is missing, and no extra vld occurs.
- With PWM_CAP_GLITCH_EN and GLITCH=3: 2-cycle high spike inside a low phase -> ignored, per unchanged. Same stimulus without the macro -> a spurious short measurement (hi=2) is reported.
